// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_if: start/value request and registered BCD result bundle for bin_to_bcd_seq.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     lz_mask;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, lz_mask, overflow);
    modport slave  (input start, bin, output busy, done, bcd, lz_mask, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with blanking mask and overflow.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic          clk,
    input logic          rst,
    bin_to_bcd_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh;
    logic [BW-1:0]    scr, adj, bcd_r;
    logic [CW-1:0]    cnt;
    logic             ovf, ovf_r, done_r, z;
    logic [DIGITS-1:0] lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && bus.start)          state_n = SHIFT;
        else if (state == SHIFT && cnt == CW'(1)) state_n = DONE;
        else if (state == DONE)                  state_n = IDLE;
    end

    // per-digit add-3 with no carry between digits
    always_comb begin
        adj = scr;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = scr[4*i +: 4] >= 4'd5 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh     <= '0;
            scr    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            bcd_r  <= '0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= state == DONE;
            if (state == IDLE && bus.start) begin
                sh  <= bus.bin;
                scr <= '0;
                ovf <= 1'b0;
                cnt <= CW'(WIDTH);
            end else if (state == SHIFT) begin
                scr <= {adj[BW-2:0], sh[WIDTH-1]};
                sh  <= {sh[WIDTH-2:0], 1'b0};
                ovf <= ovf | adj[BW-1];
                cnt <= cnt - CW'(1);
            end else if (state == DONE) begin
                bcd_r <= ovf ? {DIGITS{4'd9}} : scr;
                ovf_r <= ovf;
            end
        end
    end

    // a digit blanks only when it and every digit above it are zero; units never blank
    always_comb begin
        z  = 1'b1;
        lz = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z     = z & (bcd_r[4*i +: 4] == 4'd0);
            lz[i] = z;
        end
    end

    assign bus.busy     = state == SHIFT;
    assign bus.done     = done_r;
    assign bus.bcd      = bcd_r;
    assign bus.lz_mask  = lz;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of a 16/5 converter and a 16/4 converter fed identical requests.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) b5 ();
    bin_to_bcd_if #(.WIDTH(16), .DIGITS(4)) b4 ();

    assign b4.start = b5.start;
    assign b4.bin   = b5.bin;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen. k counts negedges after the accept edge.
    task automatic run5(input logic [15:0] v, input bit poke, output int lat, output int bc);
        b5.bin   = v;
        b5.start = 1'b1;
        @(negedge clk);
        b5.start = 1'b0;
        b5.bin   = ~v;
        lat = -1;
        bc  = 0;
        for (int k = 0; k < 40; k++) begin
            if (b5.busy) bc++;
            if (b5.done) begin
                lat = k;
                break;
            end
            if (poke && k == 5) begin b5.start = 1'b1; b5.bin = 16'd777; end
            if (poke && k == 6) b5.start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int nd = 0, nb = 0;
        #2;
        checks++; if (b5.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b5.busy); end
        checks++; if (b5.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b5.done); end
        checks++; if (b5.bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd got %h want 00000", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b11110) begin errors++; $display("FAIL reset_lz got %b want 11110", b5.lz_mask); end
        checks++; if (b5.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", b5.overflow); end
        checks++; if (b4.lz_mask !== 4'b1110) begin errors++; $display("FAIL reset_lz4 got %b want 1110", b4.lz_mask); end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (b5.done) nd++;
            if (b5.busy) nb++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL idle_done got %0d want 0", nd); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL idle_busy got %0d want 0", nb); end
    endtask

    task automatic test_zero();
        int lat, bc;
        run5(16'd0, 1'b0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got %0d want 17", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL zero_busy_cycles got %0d want 16", bc); end
        checks++; if (b5.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done got %b want 0", b5.busy); end
        checks++; if (b5.bcd !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h want 00000", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b11110) begin errors++; $display("FAIL zero_lz got %b want 11110", b5.lz_mask); end
        checks++; if (b5.overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", b5.overflow); end
        checks++; if (b4.lz_mask !== 4'b1110) begin errors++; $display("FAIL zero_lz4 got %b want 1110", b4.lz_mask); end
        @(negedge clk);
        checks++; if (b5.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", b5.done); end
        checks++; if (b5.bcd !== 20'h00000) begin errors++; $display("FAIL zero_hold got %h want 00000", b5.bcd); end
    endtask

    task automatic test_max();
        int lat, bc;
        @(negedge clk);
        run5(16'd65535, 1'b0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency got %0d want 17", lat); end
        checks++; if (b5.bcd !== 20'h65535) begin errors++; $display("FAIL max_bcd got %h want 65535", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b00000) begin errors++; $display("FAIL max_lz got %b want 00000", b5.lz_mask); end
        checks++; if (b5.overflow !== 1'b0) begin errors++; $display("FAIL max_ovf got %b want 0", b5.overflow); end
        checks++; if (b4.overflow !== 1'b1) begin errors++; $display("FAIL max_ovf4 got %b want 1", b4.overflow); end
        checks++; if (b4.bcd !== 16'h9999) begin errors++; $display("FAIL max_bcd4 got %h want 9999", b4.bcd); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        @(negedge clk);
        run5(16'd9, 1'b1, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b1_latency got %0d want 17", lat); end
        checks++; if (b5.bcd !== 20'h00009) begin errors++; $display("FAIL b2b1_bcd got %h want 00009", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b11110) begin errors++; $display("FAIL b2b1_lz got %b want 11110", b5.lz_mask); end
        run5(16'd1000, 1'b1, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b2_latency got %0d want 17", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL b2b2_busy_cycles got %0d want 16", bc); end
        checks++; if (b5.bcd !== 20'h01000) begin errors++; $display("FAIL b2b2_bcd got %h want 01000", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b10000) begin errors++; $display("FAIL b2b2_lz got %b want 10000", b5.lz_mask); end
        checks++; if (b4.bcd !== 16'h1000) begin errors++; $display("FAIL b2b2_bcd4 got %h want 1000", b4.bcd); end
        repeat (3) @(negedge clk);
        checks++; if (b5.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue got %b want 0", b5.busy); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run5(16'd12345, 1'b0, lat, bc);
        checks++; if (b4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", b4.overflow); end
        checks++; if (b4.bcd !== 16'h9999) begin errors++; $display("FAIL ovf_bcd got %h want 9999", b4.bcd); end
        checks++; if (b4.lz_mask !== 4'b0000) begin errors++; $display("FAIL ovf_lz got %b want 0000", b4.lz_mask); end
        checks++; if (b5.bcd !== 20'h12345) begin errors++; $display("FAIL ovf_bcd5 got %h want 12345", b5.bcd); end
        checks++; if (b5.overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag5 got %b want 0", b5.overflow); end
        @(negedge clk);
        run5(16'd9999, 1'b0, lat, bc);
        checks++; if (b4.overflow !== 1'b0) begin errors++; $display("FAIL edge_ovf got %b want 0", b4.overflow); end
        checks++; if (b4.bcd !== 16'h9999) begin errors++; $display("FAIL edge_bcd got %h want 9999", b4.bcd); end
        checks++; if (b5.bcd !== 20'h09999) begin errors++; $display("FAIL edge_bcd5 got %h want 09999", b5.bcd); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, nd = 0;
        @(negedge clk);
        b5.bin   = 16'd4321;
        b5.start = 1'b1;
        @(negedge clk);
        b5.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (b5.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", b5.busy); end
        checks++; if (b5.bcd !== 20'h00000) begin errors++; $display("FAIL abort_bcd got %h want 00000", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b11110) begin errors++; $display("FAIL abort_lz got %b want 11110", b5.lz_mask); end
        checks++; if (b4.bcd !== 16'h0000) begin errors++; $display("FAIL abort_bcd4 got %h want 0000", b4.bcd); end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (b5.done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end
        run5(16'd4321, 1'b0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL rerun_latency got %0d want 17", lat); end
        checks++; if (b5.bcd !== 20'h04321) begin errors++; $display("FAIL rerun_bcd got %h want 04321", b5.bcd); end
        checks++; if (b5.lz_mask !== 5'b10000) begin errors++; $display("FAIL rerun_lz got %b want 10000", b5.lz_mask); end
        #2 rst = 1'b1;
        #1;
        checks++; if (b5.done !== 1'b0) begin errors++; $display("FAIL done_async_drop got %b want 0", b5.done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b5.start = 1'b0;
        b5.bin   = '0;
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_overflow();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that produces the 4-bit decimal digits consumed by the per-digit seven-segment decoders on the DE2 HEX displays. It takes an unsigned binary value on a start strobe and runs a shift-and-add-3 (double-dabble) conversion over WIDTH clock cycles. It then presents a registered packed BCD result, a leading-zero mask for display blanking, and an overflow flag. It sits between datapath counters/accumulators and the bank of seven-segment decoders.

## Interface
- WIDTH, 16, bit width of the unsigned binary input (2..32)
- DIGITS, 5, number of BCD digits produced (1..10)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  conversion request; sampled only in IDLE
- bin  input  WIDTH  unsigned value; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; bcd/lz_mask/overflow updated in this cycle
- bcd  output  4*DIGITS  packed result, digit i at bits [4i+3:4i], digit 0 = units
- lz_mask  output  DIGITS  bit i = 1 when digit i and all higher digits are zero; bit 0 always 0
- overflow  output  1  1 when the captured value is ≥ 10^DIGITS

## Operation
- Clock is `clk`. Reset is `rst`, asynchronous and active-high. The single FSM has states IDLE, SHIFT and DONE.
- IDLE:
  - On `start`=1, capture `bin` into the shift register.
  - Clear the BCD scratch register, the sticky overflow bit and the bit counter (counter loads WIDTH).
  - Go to SHIFT.
- SHIFT, each cycle:
  - For every scratch digit ≥ 5, add 3 (4-bit add, no carry between digits).
  - Shift {scratch, shiftreg} left by 1.
  - If the bit shifted out of the top scratch digit is 1, set sticky overflow.
  - Decrement the counter. After exactly WIDTH shift cycles go to DONE.
- DONE (one cycle):
  - Register the outputs: `bcd` = scratch, or all digits 4'd9 when sticky overflow is set.
  - Drive `overflow` = sticky overflow and `lz_mask` computed from the registered `bcd` value.
  - Assert `done`, then return to IDLE.
- `start` in SHIFT or DONE is ignored; no queuing. A changing `bin` after capture does not affect the result.
- `bcd`, `lz_mask` and `overflow` hold their last values until the next DONE.
- Digits never exceed 9 in `bcd`, so downstream decoders never see their default code.
- With DIGITS large enough for 2^WIDTH−1 (e.g. 16/5), overflow can never assert.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, `lz_mask`={DIGITS-1{1'b1},1'b0}, `overflow`=0. All internal registers are cleared.
- `start` is accepted at rising edge E0. `busy`=1 from E0 until edge E0+WIDTH, i.e. WIDTH cycles.
- `done`=1 and new outputs are visible for the single cycle between E0+WIDTH+1 and E0+WIDTH+2, with `busy`=0.
- Total latency from accepted start to done is WIDTH+1 cycles. The earliest next accepted start is edge E0+WIDTH+2, giving a throughput of one conversion per WIDTH+2 cycles.
- `start` held high continuously starts a new conversion on every IDLE cycle.
- Reset mid-conversion aborts immediately to IDLE with reset output values. No `done` is produced for the aborted conversion.
- Reset asserted during the DONE cycle drops `done` asynchronously.

## Test plan
- Reset then idle:
  - All outputs at reset values; `start`=0 for 50 cycles -> no `done`, no `busy`.
- WIDTH=16, DIGITS=5, bin=0 with a single start:
  - `busy` high for exactly 16 cycles.
  - `done` 17 cycles after the start edge, `bcd`=20'h00000, `lz_mask`=5'b11110, `overflow`=0.
- WIDTH=16, DIGITS=5, bin=65535:
  - `bcd`=20'h65535, `lz_mask`=5'b00000, `overflow`=0.
- bin=9 then bin=1000, back-to-back at the earliest legal start:
  - First `bcd`=20'h00009 with `lz_mask`=5'b11110.
  - Second `bcd`=20'h01000 with `lz_mask`=5'b10000.
  - `start` pulses during busy are ignored.
- WIDTH=16, DIGITS=4, bin=12345:
  - `overflow`=1 and `bcd`=16'h9999.
  - Follow with bin=9999 -> `overflow`=0, `bcd`=16'h9999.
- Reset asserted 5 cycles into a conversion of 4321:
  - Outputs return to reset values asynchronously; no `done`.
  - A new start with 4321 yields `bcd`=20'h04321.
